mux_reg_nto1: RTL and testbench

Parametrised N-input, WIDTH-bit registered selector for the pipelined datapath; the successor to the fixed 32-bit 2:1 combinational mux. Selects one of N flattened inputs by a binary select, captures it into an output register under a valid/ready handshake, and optionally adds a skid entry so backpressure never breaks the ready path combinationally. Used at stage boundaries (forwarding, writeback source select) where the selected value must be registered and stallable.

---
 rtl/mux_reg_nto1_if.sv | 27 ++
 rtl/mux_reg_nto1.sv | 157 +++++++++++++++
 tb/tb_mux_reg_nto1.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_reg_nto1_if.sv
// mux_reg_nto1_if: upstream/downstream handshake bundle for mux_reg_nto1.
// slave is the selector's view of the bundle; master is the driving side.
interface mux_reg_nto1_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2
);
    logic [N*WIDTH-1:0] In;
    logic [SELW-1:0]    Sel;
    logic               InValid;
    logic               InReady;
    logic               Flush;
    logic [WIDTH-1:0]   Out;
    logic               OutValid;
    logic               OutReady;
    logic               SelErr;

    modport slave (
        input  In, Sel, InValid, Flush, OutReady,
        output InReady, Out, OutValid, SelErr
    );

    modport master (
        output In, Sel, InValid, Flush, OutReady,
        input  InReady, Out, OutValid, SelErr
    );
endinterface

// File: rtl/mux_reg_nto1.sv
// mux_reg_nto1: N-input registered selector with valid/ready handshake.
// Define MUXREG_SKID_EN for a registered InReady backed by one skid entry.
module mux_reg_nto1 #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic          Clk,
    input  logic          Reset_n,
    mux_reg_nto1_if.slave bus
);
`ifdef MUXREG_SKID_EN
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
`else
    typedef enum logic [1:0] {EMPTY, ONE} state_t;
`endif

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] sel_data;
    logic             bad_sel;
    logic             selerr_q;
    logic             ov;
    logic             rdy;
    logic             acc;
    logic             drn;
    logic             load_main;

    // Out-of-range selects match no arm and capture zero.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (bus.Sel == SELW'(k)) begin
                sel_data = bus.In[k*WIDTH +: WIDTH];
            end
        end
    end

    assign bad_sel = (int'(bus.Sel) >= N);
    assign ov      = (state_q != EMPTY);
    assign acc     = bus.InValid && rdy;
    assign drn     = ov && bus.OutReady;

    assign bus.Out      = out_q;
    assign bus.OutValid = ov;
    assign bus.InReady  = rdy;
    assign bus.SelErr   = selerr_q;

`ifdef MUXREG_SKID_EN
    logic [WIDTH-1:0] skid_q;
    logic             rdy_q;
    logic             load_skid;
    logic             from_skid;

    assign rdy = rdy_q;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        from_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (acc && drn) begin
                    load_main = 1'b1;
                end else if (acc) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (drn) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drn) begin
                    state_d   = ONE;
                    from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins: nothing held or offered survives, Out keeps its value.
        if (bus.Flush) begin
            state_d   = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
            from_skid = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            skid_q <= '0;
            rdy_q  <= 1'b1;
        end else begin
            rdy_q <= (state_d != FULL);
            if (load_skid) begin
                skid_q <= sel_data;
            end
        end
    end
`else
    assign rdy = !ov || bus.OutReady;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (acc) begin
                    load_main = 1'b1;
                end else if (drn) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (bus.Flush) begin
            state_d   = EMPTY;
            load_main = 1'b0;
        end
    end
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= EMPTY;
            out_q    <= '0;
            selerr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (acc && bad_sel) begin
                selerr_q <= 1'b1;
            end
            if (load_main) begin
                out_q <= sel_data;
            end
`ifdef MUXREG_SKID_EN
            else if (from_skid) begin
                out_q <= skid_q;
            end
`endif
        end
    end
endmodule

// File: tb/tb_mux_reg_nto1.sv
// tb_mux_reg_nto1: directed and random traffic on a 4x32 and a 3x16 selector
// against a queue model of the accepted-but-not-drained entries.
module tb_mux_reg_nto1;
    logic Clk = 1'b0;
    logic Reset_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 Clk = ~Clk;

    mux_reg_nto1_if #(.WIDTH(32), .N(4), .SELW(2)) b4 ();
    mux_reg_nto1_if #(.WIDTH(16), .N(3), .SELW(2)) b3 ();

    mux_reg_nto1 #(.WIDTH(32), .N(4), .SELW(2)) dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .bus(b4.slave)
    );
    mux_reg_nto1 #(.WIDTH(16), .N(3), .SELW(2)) dut3 (
        .Clk(Clk), .Reset_n(Reset_n), .bus(b3.slave)
    );

    // Model: queue of held entries, last Out value, sticky error.
    logic [31:0] q4[$];
    logic [15:0] q3[$];
    logic [31:0] eo4;
    logic [15:0] eo3;
    logic        er4;
    logic        er3;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic exp_rdy(int sz, logic ordy);
`ifdef MUXREG_SKID_EN
        return (sz < 2);
`else
        return (sz == 0) || ordy;
`endif
    endfunction

    task automatic model_reset();
        q4.delete();
        q3.delete();
        eo4 = '0;
        eo3 = '0;
        er4 = 1'b0;
        er3 = 1'b0;
    endtask

    task automatic check_outs(string tag);
        check({tag, ".ov4"}, 32'(b4.OutValid), 32'(q4.size() > 0));
        check({tag, ".out4"}, b4.Out, eo4);
        check({tag, ".rdy4"}, 32'(b4.InReady),
              32'(exp_rdy(q4.size(), b4.OutReady)));
        check({tag, ".err4"}, 32'(b4.SelErr), 32'(er4));
        check({tag, ".ov3"}, 32'(b3.OutValid), 32'(q3.size() > 0));
        check({tag, ".out3"}, 32'(b3.Out), 32'(eo3));
        check({tag, ".rdy3"}, 32'(b3.InReady),
              32'(exp_rdy(q3.size(), b3.OutReady)));
        check({tag, ".err3"}, 32'(b3.SelErr), 32'(er3));
    endtask

    task automatic upd4();
        logic        acc;
        logic        drn;
        logic [31:0] w;
        acc = b4.InValid && exp_rdy(q4.size(), b4.OutReady);
        drn = (q4.size() > 0) && b4.OutReady;
        w = (int'(b4.Sel) < 4) ? b4.In[int'(b4.Sel)*32 +: 32] : 32'h0;
        if (acc && int'(b4.Sel) >= 4) er4 = 1'b1;
        if (b4.Flush) begin
            q4.delete();
        end else begin
            if (drn) void'(q4.pop_front());
            if (acc) q4.push_back(w);
            if (q4.size() > 0) eo4 = q4[0];
        end
    endtask

    task automatic upd3();
        logic        acc;
        logic        drn;
        logic [15:0] w;
        acc = b3.InValid && exp_rdy(q3.size(), b3.OutReady);
        drn = (q3.size() > 0) && b3.OutReady;
        w = (int'(b3.Sel) < 3) ? b3.In[int'(b3.Sel)*16 +: 16] : 16'h0;
        if (acc && int'(b3.Sel) >= 3) er3 = 1'b1;
        if (b3.Flush) begin
            q3.delete();
        end else begin
            if (drn) void'(q3.pop_front());
            if (acc) q3.push_back(w);
            if (q3.size() > 0) eo3 = q3[0];
        end
    endtask

    // Inputs change at posedge+1; outputs are checked at the negedge.
    task automatic tick(string tag);
        @(negedge Clk);
        check_outs(tag);
        upd4();
        upd3();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_idle();
        b4.In = '0; b4.Sel = '0; b4.InValid = 1'b0;
        b4.Flush = 1'b0; b4.OutReady = 1'b0;
        b3.In = '0; b3.Sel = '0; b3.InValid = 1'b0;
        b3.Flush = 1'b0; b3.OutReady = 1'b0;
    endtask

    logic [31:0] sweep [4];

    initial begin
        sweep = '{32'hAAAA_AAAA, 32'hBBBB_BBBB,
                  32'hCCCC_CCCC, 32'hDDDD_DDDD};
        Reset_n = 1'b0;
        set_idle();
        model_reset();
        #3;
        check_outs("reset");
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Select sweep, one accept per cycle.
        b4.In = {32'hDDDD_DDDD, 32'hCCCC_CCCC,
                 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        b4.OutReady = 1'b1;
        b4.InValid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b4.Sel = 2'(k);
            tick("sweep");
            check("sweep.out", b4.Out, sweep[k]);
            check("sweep.ov", 32'(b4.OutValid), 32'h1);
        end
        b4.InValid = 1'b0;
        tick("sweep.drain");

        // Out-of-range select on the 3-input unit.
        b3.In = {3{16'h1234}};
        b3.Sel = 2'd3;
        b3.InValid = 1'b1;
        b3.OutReady = 1'b1;
        tick("oor");
        check("oor.out", 32'(b3.Out), 32'h0);
        check("oor.ov", 32'(b3.OutValid), 32'h1);
        check("oor.err", 32'(b3.SelErr), 32'h1);
        b3.Sel = 2'd1;
        for (int k = 0; k < 3; k++) begin
            tick("oor.after");
            check("oor.sticky", 32'(b3.SelErr), 32'h1);
        end
        set_idle();
        tick("oor.drain");

`ifdef MUXREG_SKID_EN
        // Backpressure: two entries held, third waits.
        b4.OutReady = 1'b0;
        b4.InValid  = 1'b1;
        b4.Sel      = 2'd0;
        for (int v = 1; v <= 3; v++) begin
            b4.In = {4{32'(v)}};
            tick("bp.fill");
        end
        check("bp.rdy", 32'(b4.InReady), 32'h0);
        check("bp.hold", b4.Out, 32'h1);
        b4.OutReady = 1'b1;
        tick("bp.rel");
        check("bp.out2", b4.Out, 32'h2);
        tick("bp.rel");
        check("bp.out3", b4.Out, 32'h3);
        b4.InValid = 1'b0;
        tick("bp.rel");
        check("bp.empty", 32'(b4.OutValid), 32'h0);
`else
        // Combinational ready follows OutReady while holding data.
        b4.OutReady = 1'b0;
        b4.InValid  = 1'b1;
        b4.Sel      = 2'd0;
        b4.In       = {4{32'h1}};
        tick("nr.fill");
        b4.In = {4{32'h2}};
        #1;
        check("nr.rdy0", 32'(b4.InReady), 32'h0);
        b4.OutReady = 1'b1;
        #1;
        check("nr.rdy1", 32'(b4.InReady), 32'h1);
        tick("nr.reload");
        check("nr.out", b4.Out, 32'h2);
        check("nr.ov", 32'(b4.OutValid), 32'h1);
        b4.InValid = 1'b0;
        tick("nr.drain");
`endif

        // Flush colliding with an offer and a drain.
        set_idle();
        b4.InValid = 1'b1;
        b4.In = {4{32'h5}};
        tick("fl.fill");
        b4.In = {4{32'h6}};
        tick("fl.fill");
        b4.Flush = 1'b1;
        b4.OutReady = 1'b1;
        b4.In = {4{32'h7}};
        tick("fl.hit");
        b4.Flush = 1'b0;
        b4.InValid = 1'b0;
        check("fl.ov", 32'(b4.OutValid), 32'h0);
        check("fl.rdy", 32'(b4.InReady), 32'h1);
        check("fl.out", b4.Out, 32'h5);
        for (int k = 0; k < 3; k++) tick("fl.after");

        // Random traffic on both units.
        for (int i = 0; i < 400; i++) begin
            b4.In = {$urandom, $urandom, $urandom, $urandom};
            b4.Sel = 2'($urandom_range(0, 3));
            b4.InValid = ($urandom_range(0, 3) != 0);
            b4.OutReady = ($urandom_range(0, 2) != 0);
            b4.Flush = ($urandom_range(0, 19) == 0);
            b3.In = {16'($urandom), 16'($urandom), 16'($urandom)};
            b3.Sel = 2'($urandom_range(0, 3));
            b3.InValid = ($urandom_range(0, 3) != 0);
            b3.OutReady = ($urandom_range(0, 2) != 0);
            b3.Flush = ($urandom_range(0, 19) == 0);
            if (b3.Flush) b3.Sel = 2'($urandom_range(0, 2));
            tick("rnd");
        end

        // Asynchronous reset while data is held.
        b4.Flush = 1'b0;
        b3.Flush = 1'b0;
        b4.InValid = 1'b1;
        b4.OutReady = 1'b0;
        tick("rst.fill");
        check("rst.pre.ov", 32'(b4.OutValid), 32'h1);
        Reset_n = 1'b0;
        #1;
        model_reset();
        check("rst.ov", 32'(b4.OutValid), 32'h0);
        check("rst.out", b4.Out, 32'h0);
        check("rst.rdy", 32'(b4.InReady), 32'h1);
        check("rst.err4", 32'(b4.SelErr), 32'h0);
        check("rst.err3", 32'(b3.SelErr), 32'h0);
        set_idle();
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        tick("rst.after");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
